// File: rtl/btb_assoc_pkg.sv
// rv32i_types: shared fetch-stage types for the branch target buffer.
//   btb_entry_t : one BTB way (valid, tag, target). The tag field is sized for
//                 the smallest legal index (S_INDEX=1 gives a WIDTH-3 bit tag),
//                 so narrower tags are stored zero-extended.
//   btb_state_t : BTB control FSM states.
package rv32i_types;

    localparam int unsigned BTB_XLEN  = 32;
    localparam int unsigned BTB_TAG_W = BTB_XLEN - 3;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_XLEN-1:0]  target;
    } btb_entry_t;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_FLUSH = 1'b1
    } btb_state_t;

endpackage

// File: rtl/btb_assoc_if.sv
// btb_assoc_if: fetch/resolve-side bundle of the branch target buffer.
//   flush, busy                        : invalidation sweep request / in-progress
//   lookup_en, lookup_pc               : fetch lookup request
//   hit, hit_target                    : lookup response (combinational)
//   upd_en, upd_pc, upd_target         : resolved-taken-branch write
// master = fetch/resolve pipeline side, slave = BTB.
interface btb_assoc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             busy;
    logic             lookup_en;
    logic [WIDTH-1:0] lookup_pc;
    logic             hit;
    logic [WIDTH-1:0] hit_target;
    logic             upd_en;
    logic [WIDTH-1:0] upd_pc;
    logic [WIDTH-1:0] upd_target;

    modport master (
        output flush, lookup_en, lookup_pc, upd_en, upd_pc, upd_target,
        input  busy, hit, hit_target
    );

    modport slave (
        input  flush, lookup_en, lookup_pc, upd_en, upd_pc, upd_target,
        output busy, hit, hit_target
    );
endinterface

// File: rtl/btb_assoc_plru.sv
// btb_plru: tree pseudo-LRU for one set (WAYS = 1, 2 or 4).
//   bits_i   : current PLRU bits of the set
//   touch_i  : way being touched
//   bits_o   : PLRU bits after the touch
//   victim_o : replacement way derived from bits_i
// Each tree bit points toward the less recently used half; a touch points
// the bits on its path away from the touched way.
module btb_plru #(
    parameter  int unsigned WAYS   = 2,
    localparam int unsigned BITS_W = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [BITS_W-1:0] bits_i,
    input  logic [WAY_W-1:0]  touch_i,
    output logic [BITS_W-1:0] bits_o,
    output logic [WAY_W-1:0]  victim_o
);

    generate
        if (WAYS == 4) begin : g_w4
            // bit0 selects the pair, bit1 the way in pair {0,1}, bit2 in {2,3}
            always_comb begin
                bits_o    = bits_i;
                bits_o[0] = ~touch_i[1];
                if (touch_i[1]) begin
                    bits_o[2] = ~touch_i[0];
                end else begin
                    bits_o[1] = ~touch_i[0];
                end
                victim_o = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
            end
        end else if (WAYS == 2) begin : g_w2
            assign bits_o   = ~touch_i;
            assign victim_o = bits_i;
        end else begin : g_w1
            logic unused_touch;
            assign unused_touch = touch_i[0];
            assign bits_o       = bits_i;
            assign victim_o     = '0;
        end
    endgenerate

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer for the fetch stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : btb_assoc_if.slave (flush/busy, lookup, update)
// Tagged, valid-qualified ways with tree PLRU replacement; flush sweeps one
// set per cycle. Optional macro BTB_BYPASS_EN forwards a same-cycle update
// matching the lookup PC onto the lookup response.
module btb_assoc
    import rv32i_types::*;
#(
    parameter int unsigned S_INDEX = 3,
    parameter int unsigned WAYS    = 2,
    parameter int unsigned WIDTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    btb_assoc_if.slave  bus
);

    localparam int unsigned SETS   = 2 ** S_INDEX;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t         mem_q  [SETS][WAYS];
    btb_entry_t         mem_d  [SETS][WAYS];
    logic [PLRU_W-1:0]  plru_q [SETS];
    logic [PLRU_W-1:0]  plru_d [SETS];
    btb_state_t         state_q, state_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;

    logic                 idle;
    logic [S_INDEX-1:0]   lk_idx, up_idx;
    logic [BTB_TAG_W-1:0] lk_tag, up_tag;
    logic                 unused_pc_lsbs;

    assign idle   = (state_q == BTB_IDLE);
    assign lk_idx = bus.lookup_pc[S_INDEX+1:2];
    assign up_idx = bus.upd_pc[S_INDEX+1:2];
    assign lk_tag = BTB_TAG_W'(bus.lookup_pc[WIDTH-1:S_INDEX+2]);
    assign up_tag = BTB_TAG_W'(bus.upd_pc[WIDTH-1:S_INDEX+2]);
    assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    // Lookup against stored state
    logic             lk_match, lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic [WIDTH-1:0] lk_target;

    always_comb begin
        lk_match  = 1'b0;
        lk_way    = '0;
        lk_target = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (mem_q[lk_idx][w].valid && mem_q[lk_idx][w].tag == lk_tag) begin
                lk_match = 1'b1;
                lk_way   = WAY_W'(w);
            end
        end
        lk_hit = bus.lookup_en && idle && lk_match;
        if (lk_hit) begin
            lk_target = mem_q[lk_idx][lk_way].target[WIDTH-1:0];
        end
    end

    // Update way selection: matching way, else lowest invalid, else PLRU victim
    logic             up_wr, up_match, up_free;
    logic [WAY_W-1:0] up_match_way, up_free_way, up_way, up_victim;

    assign up_wr = bus.upd_en && idle;

    always_comb begin
        up_match     = 1'b0;
        up_free      = 1'b0;
        up_match_way = '0;
        up_free_way  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (mem_q[up_idx][w].valid && mem_q[up_idx][w].tag == up_tag) begin
                up_match     = 1'b1;
                up_match_way = WAY_W'(w);
            end
            if (!mem_q[up_idx][w].valid && !up_free) begin
                up_free     = 1'b1;
                up_free_way = WAY_W'(w);
            end
        end
        up_way = up_match ? up_match_way : (up_free ? up_free_way : up_victim);
    end

    // The update touch starts from the lookup-touched bits when both hit the
    // same set, so the update touch wins on shared tree bits.
    logic [PLRU_W-1:0] lk_plru_nxt, up_plru_base, up_plru_nxt;
    logic [WAY_W-1:0]  lk_victim_unused;

    btb_plru #(.WAYS(WAYS)) u_plru_lk (
        .bits_i   (plru_q[lk_idx]),
        .touch_i  (lk_way),
        .bits_o   (lk_plru_nxt),
        .victim_o (lk_victim_unused)
    );

    assign up_plru_base = (lk_hit && lk_idx == up_idx) ? lk_plru_nxt : plru_q[up_idx];

    btb_plru #(.WAYS(WAYS)) u_plru_up (
        .bits_i   (up_plru_base),
        .touch_i  (up_way),
        .bits_o   (up_plru_nxt),
        .victim_o (up_victim)
    );

    always_comb begin
        mem_d   = mem_q;
        plru_d  = plru_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BTB_IDLE: begin
                if (bus.flush) begin
                    state_d = BTB_FLUSH;
                    cnt_d   = '0;
                end
                if (lk_hit) begin
                    plru_d[lk_idx] = lk_plru_nxt;
                end
                if (up_wr) begin
                    mem_d[up_idx][up_way].valid  = 1'b1;
                    mem_d[up_idx][up_way].tag    = up_tag;
                    mem_d[up_idx][up_way].target = BTB_XLEN'(bus.upd_target);
                    plru_d[up_idx]               = up_plru_nxt;
                end
            end
            BTB_FLUSH: begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    mem_d[cnt_q][w].valid = 1'b0;
                end
                plru_d[cnt_q] = '0;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = BTB_IDLE;
                end
            end
            default: state_d = BTB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BTB_IDLE;
            cnt_q   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    mem_q[s][w].valid <= 1'b0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            plru_q  <= plru_d;
        end
    end

    logic             hit_o;
    logic [WIDTH-1:0] hit_target_o;

    always_comb begin
        hit_o        = lk_hit;
        hit_target_o = lk_target;
`ifdef BTB_BYPASS_EN
        if (bus.lookup_en && up_wr && lk_idx == up_idx && lk_tag == up_tag) begin
            hit_o        = 1'b1;
            hit_target_o = bus.upd_target;
        end
`else
`endif
    end

    assign bus.hit        = hit_o;
    assign bus.hit_target = hit_target_o;
    assign bus.busy       = (state_q == BTB_FLUSH);

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    btb_assoc_if #(.WIDTH(32)) bus ();

    btb_assoc #(.S_INDEX(3), .WAYS(2), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        busy;
        logic        hit;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=0x%0h want=0x%0h", nm, fld, got, want);
        end
    endfunction

    // Monitor: every presented lookup is checked against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.lookup_en === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_lookup got=lookup want=none");
            end else begin
                e = q.pop_front();
                chk(e.name, "busy", {31'b0, bus.busy}, {31'b0, e.busy});
                chk(e.name, "hit", {31'b0, bus.hit}, {31'b0, e.hit});
                chk(e.name, "target", bus.hit_target, e.tgt);
            end
        end
    end

    task automatic step(input logic r, input logic fl,
                        input logic lk, input logic [31:0] lpc,
                        input logic up, input logic [31:0] upc, input logic [31:0] utg,
                        input logic eb, input logic eh, input logic [31:0] et,
                        input string nm);
        @(posedge clk);
        #1;
        rst            = r;
        bus.flush      = fl;
        bus.lookup_en  = lk;
        bus.lookup_pc  = lpc;
        bus.upd_en     = up;
        bus.upd_pc     = upc;
        bus.upd_target = utg;
        if (lk) q.push_back('{busy: eb, hit: eh, tgt: et, name: nm});
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "");
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, tgt, 1'b0, 1'b0, 32'h0, "");
    endtask

    task automatic look(input logic [31:0] pc, input logic eb, input logic eh,
                        input logic [31:0] et, input string nm);
        step(1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, eb, eh, et, nm);
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.lookup_en  = 1'b0;
        bus.lookup_pc  = '0;
        bus.upd_en     = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;

        // Reset state and basic write/read
        do_reset();
        do_reset();
        look(32'h40, 1'b0, 1'b0, 32'h0, "reset_miss");
        upd(32'h40, 32'h100);
        look(32'h40, 1'b0, 1'b1, 32'h100, "basic_hit");

        // Eviction: 0x40 is the PLRU victim of the third write
        upd(32'h440, 32'h200);
        upd(32'h840, 32'h300);
        look(32'h40,  1'b0, 1'b0, 32'h0,   "evict_a_0x40");
        look(32'h440, 1'b0, 1'b1, 32'h200, "evict_a_0x440");
        look(32'h840, 1'b0, 1'b1, 32'h300, "evict_a_0x840");

        // Eviction with 0x40 touched before the third write
        do_reset();
        upd(32'h40, 32'h100);
        upd(32'h440, 32'h200);
        look(32'h40, 1'b0, 1'b1, 32'h100, "evict_b_touch");
        upd(32'h840, 32'h300);
        look(32'h440, 1'b0, 1'b0, 32'h0,   "evict_b_0x440");
        look(32'h40,  1'b0, 1'b1, 32'h100, "evict_b_0x40");
        look(32'h840, 1'b0, 1'b1, 32'h300, "evict_b_0x840");

        // Rewrite of an existing tag overwrites in place
        do_reset();
        upd(32'h40, 32'h100);
        upd(32'h40, 32'h180);
        look(32'h40, 1'b0, 1'b1, 32'h180, "rewrite_0x40");
        upd(32'h440, 32'h200);
        look(32'h440, 1'b0, 1'b1, 32'h200, "rewrite_0x440");
        look(32'h40,  1'b0, 1'b1, 32'h180, "rewrite_0x40_b");
        upd(32'h840, 32'h300);
        look(32'h440, 1'b0, 1'b0, 32'h0,   "rewrite_evict_0x440");
        look(32'h40,  1'b0, 1'b1, 32'h180, "rewrite_keep_0x40");
        look(32'h840, 1'b0, 1'b1, 32'h300, "rewrite_0x840");

        // Flush sweep: busy for 8 cycles, lookups miss, update and flush ignored
        do_reset();
        upd(32'h40, 32'h100);
        upd(32'h44, 32'h104);
        upd(32'h5C, 32'h11C);
        look(32'h44, 1'b0, 1'b1, 32'h104, "preflush_0x44");
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, "flush_cycle");
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, (i == 4), 1'b1, 32'h5C, (i == 3), 32'h80, 32'h400,
                 1'b1, 1'b0, 32'h0, $sformatf("sweep_%0d", i));
        end
        look(32'h40, 1'b0, 1'b0, 32'h0, "postflush_0x40");
        look(32'h44, 1'b0, 1'b0, 32'h0, "postflush_0x44");
        look(32'h5C, 1'b0, 1'b0, 32'h0, "postflush_0x5C");
        look(32'h80, 1'b0, 1'b0, 32'h0, "postflush_dropped_0x80");

        // Reset during the sweep clears every set at once
        upd(32'h40, 32'h100);
        upd(32'h5C, 32'h11C);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "");
        look(32'h40, 1'b1, 1'b0, 32'h0, "midflush_1");
        look(32'h40, 1'b1, 1'b0, 32'h0, "midflush_2");
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "midflush_rst");
        look(32'h5C, 1'b0, 1'b0, 32'h0, "after_rst_0x5C");
        look(32'h40, 1'b0, 1'b0, 32'h0, "after_rst_0x40");

        // Same-cycle lookup and update on an empty BTB
        do_reset();
`ifdef BTB_BYPASS_EN
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b1, 32'h100, "same_cycle");
`else
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 32'h0, "same_cycle");
`endif
        look(32'h40, 1'b0, 1'b1, 32'h100, "same_cycle_next");

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "");
        @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_expectations got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
